// File: rtl/robot_icon_gen.sv
// Rojobot icon sprite generator: draws a rotated 2-bpp bitmap at the bot's location in step
// with the DTG scan. The output has a fixed two-cycle latency, and 12'h000 means transparent.
module robot_icon_gen #(
    parameter int unsigned ICON_SIZE    = 16,
    parameter int unsigned SCALE_SHIFT  = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic        frame_start,
    input  logic        upd_sysregs,
    input  logic [7:0]  loc_x,
    input  logic [7:0]  loc_y,
    input  logic [2:0]  orient,
    output logic [11:0] icon
);

    localparam int unsigned AW   = $clog2(ICON_SIZE);
    localparam int unsigned HALF = ICON_SIZE / 2;
    localparam int unsigned IMAX = ICON_SIZE - 1;
    localparam logic [AW-1:0] NMAX = AW'(IMAX);
    localparam logic signed [12:0] SIZE_S = 13'(ICON_SIZE);
    localparam logic signed [12:0] HALF_S = 13'(HALF);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
        logic [2:0] o;
    } bot_t;

    bot_t in_bot;
    bot_t pend_q, pend_d;
    bot_t act_q, act_d;

    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    logic unused_loc_msb;
    assign unused_loc_msb = loc_x[7] ^ loc_y[7];

    always_comb begin
        in_bot.x = loc_x[6:0];
        in_bot.y = loc_y[6:0];
        in_bot.o = orient;
    end

    // Bot state shadow registers; simultaneous update and frame start take the port values.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (upd_sysregs) begin
            pend_d = in_bot;
        end
        if (frame_start) begin
            act_d = upd_sysregs ? in_bot : pend_q;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q      <= '0;
            act_q       <= '0;
            blink_cnt_q <= 8'd0;
            blink_ph_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            act_q       <= act_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Box geometry in 13-bit signed arithmetic; a negative origin just clips at the screen edge.
    logic signed [12:0] cx, cy, ox, oy, dc, dr;
    logic               in_box;
    logic [AW-1:0]      c_loc, r_loc;
    logic [AW-1:0]      ar, ac;

    always_comb begin
        cx     = $signed(13'(act_q.x) << SCALE_SHIFT);
        cy     = $signed(13'(act_q.y) << SCALE_SHIFT);
        ox     = cx - HALF_S;
        oy     = cy - HALF_S;
        dc     = $signed({1'b0, pixel_column}) - ox;
        dr     = $signed({1'b0, pixel_row}) - oy;
        in_box = (dc >= 13'sd0) && (dc < SIZE_S) && (dr >= 13'sd0) && (dr < SIZE_S);
        c_loc  = dc[AW-1:0];
        r_loc  = dr[AW-1:0];
    end

    always_comb begin
        ar = r_loc;
        ac = c_loc;
        case (act_q.o[2:1])
            2'd0: begin
                ar = r_loc;
                ac = c_loc;
            end
            2'd1: begin
                ar = NMAX - c_loc;
                ac = r_loc;
            end
            2'd2: begin
                ar = NMAX - r_loc;
                ac = NMAX - c_loc;
            end
            default: begin
                ar = c_loc;
                ac = NMAX - r_loc;
            end
        endcase
    end

    // Procedural bitmaps so the icon scales with ICON_SIZE.
    // B0 (north): marker bar in the top half, body in the lower half, outline on the bottom row.
    // B1 (north-east): marker on the upper anti-diagonal, body below the diagonal, outline left.
    function automatic logic [1:0] rom_code(input logic sel, input logic [AW-1:0] rr,
                                            input logic [AW-1:0] cc);
        int unsigned ri;
        int unsigned ci;
        logic [1:0]  code;
        ri   = 32'(rr);
        ci   = 32'(cc);
        code = 2'b00;
        if (!sel) begin
            if (ri == IMAX) begin
                code = 2'b11;
            end else if ((ri < HALF) && ((ci == HALF - 1) || (ci == HALF))) begin
                code = 2'b10;
            end else if ((ri >= HALF) && (ci >= 1) && (ci <= IMAX - 3)) begin
                code = 2'b01;
            end
        end else begin
            if (ci == 0) begin
                code = 2'b11;
            end else if ((ri + ci == IMAX) && (ri < HALF)) begin
                code = 2'b10;
            end else if (ri > ci) begin
                code = 2'b01;
            end
        end
        return code;
    endfunction

    logic          s1_in_box_q, s1_video_q, s1_sel_q;
    logic [AW-1:0] s1_ar_q, s1_ac_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_in_box_q <= 1'b0;
            s1_video_q  <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_ar_q     <= '0;
            s1_ac_q     <= '0;
        end else begin
            s1_in_box_q <= in_box;
            s1_video_q  <= video_on;
            s1_sel_q    <= act_q.o[0];
            s1_ar_q     <= ar;
            s1_ac_q     <= ac;
        end
    end

    logic [1:0]  pix_code;
    logic [11:0] icon_d, icon_q;

    always_comb begin
        pix_code = rom_code(s1_sel_q, s1_ar_q, s1_ac_q);
        icon_d   = 12'h000;
        if (s1_in_box_q && s1_video_q) begin
            case (pix_code)
                2'b01:   icon_d = 12'hF00;
                2'b10:   icon_d = blink_ph_q ? 12'hFF0 : 12'h0F0;
                2'b11:   icon_d = 12'h111;
                default: icon_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icon_q <= 12'h000;
        end else begin
            icon_q <= icon_d;
        end
    end

    assign icon = icon_q;

endmodule

// File: tb/tb_robot_icon_gen.sv
// Directed bench for robot_icon_gen: streams pixels each cycle and checks the icon output
// two cycles later against hand values or a small rotate/palette model.
module tb_robot_icon_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        frame_start;
    logic        upd_sysregs;
    logic [7:0]  loc_x;
    logic [7:0]  loc_y;
    logic [2:0]  orient;
    logic [11:0] icon;

    always #5 clk = ~clk;

    robot_icon_gen #(
        .ICON_SIZE   (16),
        .SCALE_SHIFT (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .video_on    (video_on),
        .pixel_row   (pixel_row),
        .pixel_column(pixel_column),
        .frame_start (frame_start),
        .upd_sysregs (upd_sysregs),
        .loc_x       (loc_x),
        .loc_y       (loc_y),
        .orient      (orient),
        .icon        (icon)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of bot state and blink
    int m_px, m_py, m_po, m_ax, m_ay, m_ao, m_cnt;
    bit m_ph;
    logic [11:0] prev_exp;
    string       prev_tag;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: icon=%h expected=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic int bmp(input int sel, input int ar, input int ac);
        if (sel == 0) begin
            if (ar == 15) return 3;
            if (ar < 8 && (ac == 7 || ac == 8)) return 2;
            if (ar >= 8 && ac >= 1 && ac <= 12) return 1;
            return 0;
        end
        if (ac == 0) return 3;
        if (ar + ac == 15 && ar < 8) return 2;
        if (ar > ac) return 1;
        return 0;
    endfunction

    function automatic logic [11:0] model_pix(input int row, input int col, input bit vid);
        int ox, oy, r, c, ar, ac, code;
        if (!vid) return 12'h000;
        ox = m_ax * 4 - 8;
        oy = m_ay * 4 - 8;
        c  = col - ox;
        r  = row - oy;
        if (c < 0 || c > 15 || r < 0 || r > 15) return 12'h000;
        case (m_ao / 2)
            0: begin ar = r;      ac = c;      end
            1: begin ar = 15 - c; ac = r;      end
            2: begin ar = 15 - r; ac = 15 - c; end
            default: begin ar = c; ac = 15 - r; end
        endcase
        code = bmp(m_ao % 2, ar, ac);
        case (code)
            1: return 12'hF00;
            2: return m_ph ? 12'hFF0 : 12'h0F0;
            3: return 12'h111;
            default: return 12'h000;
        endcase
    endfunction

    // One clock: drive inputs, advance the model, check the pixel driven one call earlier.
    task automatic cyc(input string tag, input bit vid, input int r, input int c, input bit f,
                       input bit u, input int x, input int y, input int o, input bit hand_en,
                       input logic [11:0] hand);
        logic [11:0] new_exp;
        video_on     = vid;
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        frame_start  = f;
        upd_sysregs  = u;
        loc_x        = 8'(x);
        loc_y        = 8'(y);
        orient       = 3'(o);
        if (reset) begin
            new_exp = 12'h000;
            m_px = 0; m_py = 0; m_po = 0; m_ax = 0; m_ay = 0; m_ao = 0;
            m_cnt = 0; m_ph = 0;
        end else begin
            new_exp = hand_en ? hand : model_pix(r, c, vid);
            if (f) begin
                if (u) begin
                    m_ax = x % 128; m_ay = y % 128; m_ao = o;
                end else begin
                    m_ax = m_px; m_ay = m_py; m_ao = m_po;
                end
                if (m_cnt == 1) begin
                    m_cnt = 0;
                    m_ph  = !m_ph;
                end else begin
                    m_cnt++;
                end
            end
            if (u) begin
                m_px = x % 128; m_py = y % 128; m_po = o;
            end
        end
        @(posedge clk);
        #1;
        check(prev_tag, icon, reset ? 12'h000 : prev_exp);
        prev_exp = new_exp;
        prev_tag = tag;
    endtask

    task automatic pix(input string tag, input int r, input int c);
        cyc(tag, 1, r, c, 0, 0, 0, 0, 0, 0, 12'h000);
    endtask

    task automatic pixh(input string tag, input int r, input int c, input logic [11:0] e);
        cyc(tag, 1, r, c, 0, 0, 0, 0, 0, 1, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
    endtask

    task automatic ctl(input bit f, input bit u, input int x, input int y, input int o);
        cyc("ctl", 0, 0, 0, f, u, x, y, o, 0, 12'h000);
        idle(2);
    endtask

    task automatic scan(input string tag, input int r0, input int r1, input int c0,
                        input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++) pix(tag, r, c);
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        video_on = 1'b0; pixel_row = '0; pixel_column = '0;
        frame_start = 1'b0; upd_sysregs = 1'b0;
        loc_x = '0; loc_y = '0; orient = '0;
        prev_exp = 12'h000;
        prev_tag = "start";

        // 1: reset with an in-box pixel; first pixel two cycles after release
        for (int i = 0; i < 3; i++) pix("t1_reset", 4, 4);
        reset = 1'b0;
        pixh("t1_first", 4, 4, 12'hF00);
        pixh("t1_next", 4, 4, 12'hF00);
        idle(2);

        // 2: centred at (64,64), heading N
        ctl(0, 1, 64, 64, 0);
        ctl(1, 0, 0, 0, 0);
        pixh("t2_corner", 248, 248, 12'h000);
        pixh("t2_marker", 248, 255, 12'h0F0);
        pixh("t2_outline", 263, 250, 12'h111);
        pixh("t2_body", 258, 252, 12'hF00);
        pixh("t2_above", 247, 256, 12'h000);
        pixh("t2_marker2", 250, 256, 12'h0F0);
        idle(2);
        scan("t2_box", 247, 264, 247, 264);

        // 3: corner (0,0) heading E, clipped; fs+upd together (second frame -> phase 1)
        ctl(1, 1, 0, 0, 2);
        pixh("t3_marker", 0, 0, 12'hFF0);
        pixh("t3_marker2", 0, 5, 12'hFF0);
        pixh("t3_blank", 7, 0, 12'h000);
        pixh("t3_blank2", 3, 7, 12'h000);
        pixh("t3_r4095", 4095, 0, 12'h000);
        pixh("t3_c4095", 0, 4095, 12'h000);
        pixh("t3_rc4095", 4095, 4095, 12'h000);
        idle(2);
        scan("t3_box", 0, 9, 0, 9);
        scan("t3_wrap", 4095, 4095, 0, 9);

        // 4: mid-frame update held off until frame start
        ctl(1, 1, 64, 64, 0);
        pixh("t4_old", 248, 255, 12'hFF0);
        cyc("t4_upd", 1, 248, 255, 0, 1, 10, 20, 0, 1, 12'hFF0);
        pixh("t4_still_old", 248, 255, 12'hFF0);
        pixh("t4_new_hidden", 72, 39, 12'h000);
        idle(2);
        ctl(1, 0, 0, 0, 0);
        pixh("t4_new_shown", 72, 39, 12'h0F0);
        pixh("t4_old_gone", 248, 255, 12'h000);
        idle(2);
        ctl(1, 1, 100, 5, 0);
        pixh("t4_same_cycle", 12, 399, 12'h0F0);
        pixh("t4_prev_gone", 72, 39, 12'h000);

        // mid-stream reset drops the in-flight pixel
        pixh("t4_pre_reset", 12, 399, 12'h0F0);
        reset = 1'b1;
        pix("t5_reset", 12, 399);
        reset = 1'b0;
        pixh("t5_after_reset", 12, 399, 12'h000);
        idle(2);

        // 5: blink pattern with BLINK_FRAMES=2
        ctl(0, 1, 64, 64, 0);
        begin
            logic [11:0] blink_exp [4];
            blink_exp[0] = 12'h0F0;
            blink_exp[1] = 12'hFF0;
            blink_exp[2] = 12'hFF0;
            blink_exp[3] = 12'h0F0;
            for (int k = 0; k < 4; k++) begin
                ctl(1, 0, 0, 0, 0);
                pixh($sformatf("t5_blink%0d", k), 248, 255, blink_exp[k]);
                pixh($sformatf("t5_outline%0d", k), 263, 250, 12'h111);
                idle(2);
            end
        end

        // 6: orientation sweep against the reference model
        for (int o = 0; o < 8; o++) begin
            ctl(1, 1, 64, 64, o);
            scan($sformatf("t6_orient%0d", o), 247, 264, 247, 264);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
